// File: rtl/sseg_mux_n.sv
// sseg_mux_n: self-refreshing N-digit seven-segment controller with hex or
// sequential shift-add-3 signed decimal, leading-zero blanking and overflow.
module sseg_mux_n #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              hex_dec,
    input  logic              sign,
    input  logic [DIGITS-1:0] dp_in,
    input  logic              upd,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);
    localparam int BCD_MIN = DATA_W * 30103 / 100000 + 1;
    localparam int BCD_N   = BCD_MIN > DIGITS ? BCD_MIN : DIGITS;
    localparam int RW      = $clog2(REFRESH_DIV);
    localparam int IW      = $clog2(DIGITS);
    localparam int CW      = $clog2(DATA_W + 1);
    localparam logic [4:0] BLANK = 5'd16;
    localparam logic [4:0] MINUS = 5'd17;

    logic [RW-1:0]               rcnt;
    logic [IW-1:0]               idx;
    logic [DIGITS-1:0][4:0]      disp, hex_disp, dec_disp;
    logic [DIGITS-1:0]           dp_r;
    logic [BCD_N-1:0][3:0]       bcd, adj;
    logic [DATA_W-1:0]           mag, mag_in;
    logic [CW-1:0]               cnt;
    logic                        neg_r, ovf_n;
    logic [4*DIGITS-1:0]         hx;
    int                          msd;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:    glyph = 7'b1000000;
            5'd1:    glyph = 7'b1111001;
            5'd2:    glyph = 7'b0100100;
            5'd3:    glyph = 7'b0110000;
            5'd4:    glyph = 7'b0011001;
            5'd5:    glyph = 7'b0010010;
            5'd6:    glyph = 7'b0000010;
            5'd7:    glyph = 7'b1111000;
            5'd8:    glyph = 7'b0000000;
            5'd9:    glyph = 7'b0010000;
            5'd10:   glyph = 7'b0001000;
            5'd11:   glyph = 7'b0000011;
            5'd12:   glyph = 7'b1000110;
            5'd13:   glyph = 7'b0100001;
            5'd14:   glyph = 7'b0000110;
            5'd15:   glyph = 7'b0001110;
            5'd17:   glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // magnitude fits DATA_W bits unsigned even for the most negative input
    always_comb mag_in = (sign & data[DATA_W-1]) ? ~data + DATA_W'(1) : data;

    always_comb begin
        for (int i = 0; i < BCD_N; i++)
            adj[i] = bcd[i] > 4'd4 ? bcd[i] + 4'd3 : bcd[i];
    end

    always_comb begin
        hx    = (4*DIGITS)'(data);
        msd   = 0;
        ovf_n = 1'b0;
        for (int i = 0; i < BCD_N; i++) begin
            if (|bcd[i]) begin
                msd = i;
                if (i >= DIGITS - int'(neg_r)) ovf_n = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            hex_disp[i] = {1'b0, hx[4*i +: 4]};
            dec_disp[i] = (ovf_n || (neg_r && i == DIGITS - 1)) ? MINUS :
                          (BLANK_LZ != 0 && i > msd) ? BLANK : {1'b0, bcd[i]};
        end
    end

    assign seg = glyph(disp[idx]);
    assign dp  = ~dp_r[idx];
    assign an  = ~(DIGITS'(1) << idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt  <= '0;
            idx   <= '0;
            disp  <= '0;
            dp_r  <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            bcd   <= '0;
            mag   <= '0;
            cnt   <= '0;
            neg_r <= 1'b0;
        end else begin
            rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + RW'(1);
            if (rcnt == RW'(REFRESH_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
            if (busy) begin
                if (cnt == CW'(DATA_W)) begin
                    disp <= dec_disp;
                    ovf  <= ovf_n;
                    busy <= 1'b0;
                end else begin
                    bcd <= (4*BCD_N)'({adj, mag[DATA_W-1]});
                    mag <= mag << 1;
                    cnt <= cnt + CW'(1);
                end
            end else if (upd) begin
                dp_r <= dp_in;
                if (hex_dec) begin
                    disp <= hex_disp;
                    ovf  <= 1'b0;
                end else begin
                    mag   <= mag_in;
                    neg_r <= sign & data[DATA_W-1];
                    bcd   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            end
        end
    end
endmodule
